// File: rtl/llm_pkg.sv
// Shared colour and conditioner-state encodings for the traffic-light FSM and its front end.
// Also provides the committed-colour to one-hot lamp decode.
package llm_pkg;

  typedef enum logic [1:0] {
    COL_NONE   = 2'd0,
    COL_GREEN  = 2'd1,
    COL_YELLOW = 2'd2,
    COL_RED    = 2'd3
  } colour_e;

  typedef enum logic [1:0] {
    ST_STEADY  = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_HOLD    = 2'd2
  } cond_state_e;

  // Returns {red, yellow, green}; at most one bit is ever set.
  function automatic logic [2:0] colour_onehot(input colour_e c);
    logic [2:0] lamps;
    lamps = 3'b000;
    unique case (c)
      COL_GREEN:  lamps = 3'b001;
      COL_YELLOW: lamps = 3'b010;
      COL_RED:    lamps = 3'b100;
      default:    lamps = 3'b000;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/light_sync2.sv
// Two-flop synchronizer for one asynchronous sensor line; reset clears both flops.
module light_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/light_input_conditioner.sv
// Synchronizes, debounces and priority-resolves the raw light lines into a one-hot colour.
// Optional glitch counter enabled by defining LIGHT_COND_GLITCH_CNT_EN.
module light_input_conditioner
  import llm_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MIN_HOLD      = 8,
  parameter int GLITCH_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                raw_green,
  input  logic                raw_yellow,
  input  logic                raw_red,
  output logic                green,
  output logic                yellow,
  output logic                red,
  output logic [1:0]          color_code,
  output logic                change_pulse,
  output logic [1:0]          cond_state,
  output logic [GLITCH_W-1:0] glitch_count
);

  // Counters are one value wider than their limit so the increment never wraps.
  localparam int QW = $clog2(STABLE_CYCLES + 2);
  localparam int HW = $clog2(MIN_HOLD + 2);

  logic        sync_green, sync_yellow, sync_red;
  colour_e     cand, committed, pending;
  cond_state_e state;
  logic [QW-1:0] qual_cnt, qual_inc;
  logic [HW-1:0] hold_cnt, hold_inc;

  light_sync2 u_sync_green  (.clock(clock), .reset(reset), .d(raw_green),  .q(sync_green));
  light_sync2 u_sync_yellow (.clock(clock), .reset(reset), .d(raw_yellow), .q(sync_yellow));
  light_sync2 u_sync_red    (.clock(clock), .reset(reset), .d(raw_red),    .q(sync_red));

  always_comb begin
    cand = COL_NONE;
    if (sync_red)         cand = COL_RED;
    else if (sync_yellow) cand = COL_YELLOW;
    else if (sync_green)  cand = COL_GREEN;
  end

  assign qual_inc = qual_cnt + 1'b1;
  assign hold_inc = hold_cnt + 1'b1;

  // Qualify / hold state machine; lamp outputs are registered alongside the commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_STEADY;
      committed    <= COL_NONE;
      pending      <= COL_NONE;
      qual_cnt     <= '0;
      hold_cnt     <= '0;
      change_pulse <= 1'b0;
      green        <= 1'b0;
      yellow       <= 1'b0;
      red          <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      unique case (state)
        ST_STEADY: begin
          if (cand != committed) begin
            pending  <= cand;
            qual_cnt <= QW'(1);
            state    <= ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (cand == committed) begin
            state <= ST_STEADY;
          end else if (cand != pending) begin
            pending  <= cand;
            qual_cnt <= QW'(1);
          end else if (qual_inc >= QW'(STABLE_CYCLES)) begin
            committed             <= pending;
            {red, yellow, green}  <= colour_onehot(pending);
            change_pulse          <= 1'b1;
            hold_cnt              <= '0;
            state                 <= (MIN_HOLD == 0) ? ST_STEADY : ST_HOLD;
          end else begin
            qual_cnt <= qual_inc;
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_inc;
          if (hold_inc >= HW'(MIN_HOLD)) state <= ST_STEADY;
        end
        default: state <= ST_STEADY;
      endcase
    end
  end

  assign color_code = committed;
  assign cond_state = state;

`ifdef LIGHT_COND_GLITCH_CNT_EN
  // A glitch is any candidate abandoned before it qualified.
  logic                glitch_ev;
  logic [GLITCH_W-1:0] glitch_q;

  assign glitch_ev = (state == ST_QUALIFY) && ((cand == committed) || (cand != pending));

  always_ff @(posedge clock) begin
    if (reset) begin
      glitch_q <= '0;
    end else if (glitch_ev && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_count = glitch_q;
`else
  assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_light_input_conditioner.sv
// Directed plus randomized bench for light_input_conditioner with a timestamp-based reference model.
module tb_light_input_conditioner;

  localparam int STABLE_CYCLES = 4;
  localparam int MIN_HOLD      = 8;
  localparam int GLITCH_W      = 8;
`ifdef LIGHT_COND_GLITCH_CNT_EN
  localparam bit GCNT_EN = 1'b1;
`else
  localparam bit GCNT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic raw_green = 1'b0, raw_yellow = 1'b0, raw_red = 1'b0;
  logic green, yellow, red, change_pulse;
  logic [1:0] color_code, cond_state;
  logic [GLITCH_W-1:0] glitch_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clock = ~clock;

  light_input_conditioner #(
    .STABLE_CYCLES(STABLE_CYCLES), .MIN_HOLD(MIN_HOLD), .GLITCH_W(GLITCH_W)
  ) dut (
    .clock(clock), .reset(reset),
    .raw_green(raw_green), .raw_yellow(raw_yellow), .raw_red(raw_red),
    .green(green), .yellow(yellow), .red(red),
    .color_code(color_code), .change_pulse(change_pulse),
    .cond_state(cond_state), .glitch_count(glitch_count)
  );

  // Reference model: colour runs measured in edges, hold expressed as an end timestamp.
  int m_edge = 0, m_committed = 0, m_run_col = 0, m_run_len = 0, m_hold_end = -1, m_glitch = 0;
  bit m_pulse = 1'b0;
  logic [2:0] m_hist1 = 3'b000, m_hist2 = 3'b000;

  function automatic int prio(input logic [2:0] l);
    if (l[2]) return 3;
    if (l[1]) return 2;
    if (l[0]) return 1;
    return 0;
  endfunction

  task automatic bump_glitch();
    if (GCNT_EN && m_glitch < (2**GLITCH_W) - 1) m_glitch++;
  endtask

  task automatic model_edge();
    int c;
    m_edge++;
    m_pulse = 1'b0;
    if (reset) begin
      m_committed = 0; m_run_len = 0; m_run_col = 0; m_hold_end = -1; m_glitch = 0;
      m_hist1 = 3'b000; m_hist2 = 3'b000;
      return;
    end
    c = prio(m_hist2);
    m_hist2 = m_hist1;
    m_hist1 = {raw_red, raw_yellow, raw_green};
    if (m_edge <= m_hold_end) return;
    if (c == m_committed) begin
      if (m_run_len > 0) bump_glitch();
      m_run_len = 0;
    end else if (m_run_len == 0) begin
      m_run_col = c; m_run_len = 1;
    end else if (c != m_run_col) begin
      bump_glitch();
      m_run_col = c; m_run_len = 1;
    end else begin
      m_run_len++;
      if (m_run_len >= STABLE_CYCLES) begin
        m_committed = m_run_col;
        m_run_len   = 0;
        m_pulse     = 1'b1;
        m_hold_end  = m_edge + MIN_HOLD;
      end
    end
  endtask

  function automatic int exp_state();
    if (m_hold_end > m_edge) return 2;
    if (m_run_len > 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m_edge);
    end
  endtask

  task automatic check_all();
    chk("green",        int'(green),        int'(m_committed == 1));
    chk("yellow",       int'(yellow),       int'(m_committed == 2));
    chk("red",          int'(red),          int'(m_committed == 3));
    chk("color_code",   int'(color_code),   m_committed);
    chk("change_pulse", int'(change_pulse), int'(m_pulse));
    chk("cond_state",   int'(cond_state),   exp_state());
    chk("glitch_count", int'(glitch_count), m_glitch);
    chk("onehot",       int'($countones({red, yellow, green}) <= 1), 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      if (change_pulse === 1'b1) pulses++;
      check_all();
    end
  endtask

  task automatic set_raw(input logic g, input logic y, input logic r);
    raw_green = g; raw_yellow = y; raw_red = r;
  endtask

  initial begin
    int p0;
    bit found;
    @(negedge clock);

    // Reset dominates a live green input.
    set_raw(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(3);
    chk("reset_code", int'(color_code), 0);
    chk("reset_green", int'(green), 0);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      if (e < 6) chk("release_green_early", int'(green), 0);
    end
    chk("release_green", int'(green), 1);
    chk("release_pulse", int'(change_pulse), 1);
    chk("release_code", int'(color_code), 1);

    // Red outranks green.
    reset = 1'b1;
    step(2);
    set_raw(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    step(6);
    chk("prio_red", int'(red), 1);
    chk("prio_green", int'(green), 0);
    chk("prio_code", int'(color_code), 3);

    // Settle on green, then a 2-cycle red glitch.
    set_raw(1'b1, 1'b0, 1'b0);
    step(20);
    p0 = pulses;
    raw_red = 1'b1;
    step(2);
    raw_red = 1'b0;
    step(10);
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_code", int'(color_code), 1);
    chk("glitch_cnt", int'(glitch_count), GCNT_EN ? 1 : 0);

    // Green arriving during red's hold window must wait it out.
    set_raw(1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (change_pulse === 1'b1 && red === 1'b1) found = 1'b1;
    end
    chk("hold_red_commit", int'(found), 1);
    p0 = pulses;
    step(3);
    set_raw(1'b1, 1'b0, 1'b0);
    step(8);
    chk("hold_green_blocked", int'(green), 0);
    step(1);
    chk("hold_green_commit", int'(green), 1);
    chk("hold_pulse_count", pulses - p0, 1);

    // Reset while qualifying a new colour.
    step(12);
    set_raw(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (cond_state === 2'd1) found = 1'b1;
    end
    chk("midq_reached", int'(found), 1);
    reset = 1'b1;
    step(1);
    chk("midq_state", int'(cond_state), 0);
    chk("midq_code", int'(color_code), 0);
    chk("midq_lamps", int'({red, yellow, green}), 0);
    chk("midq_glitch", int'(glitch_count), 0);
    reset = 1'b0;
    set_raw(1'b0, 1'b0, 1'b0);
    step(2);

    // Randomized segments, including all-released (NONE) and occasional resets.
    for (int s = 0; s < 80; s++) begin
      set_raw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) set_raw(1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      step($urandom_range(1, 14));
    end

    // Glitch counter saturation with 300 single-cycle red glitches.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_raw(1'b1, 1'b0, 1'b0);
    step(20);
    for (int i = 0; i < 300; i++) begin
      raw_red = 1'b1;
      step(1);
      raw_red = 1'b0;
      step(1);
    end
    step(3);
    chk("sat_glitch", int'(glitch_count), GCNT_EN ? 255 : 0);
    chk("sat_code", int'(color_code), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
